int_seq: RTL and testbench
==========================

Name: int_seq

Overview:
- Interrupt/reset entry sequencer for the 6502 core.
- Arbitrates reset, NMI, BRK and IRQ at instruction boundaries and owns the memory bus for the entry sequence: stack pushes of PCH/PCL/P, then the vector fetch.
- Hands the new PC and S back to the core through load strobes.
- The core's FETCH state drives inst_boundary; the core stalls while busy=1.

Parameters:
- STACK_PAGE, 8'h01, high byte of stack addresses.
- NMI_VEC, 16'hFFFA, NMI vector LSB address (MSB at +1).
- RST_VEC, 16'hFFFC, reset vector LSB address.
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector LSB address.
- SYNC_STAGES, 2, synchronizer depth on nmi_n/irq_n (min 2).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- nmi_n  in  1  async NMI, falling-edge sensitive
- irq_n  in  1  async IRQ, level-sensitive, active-low
- brk_req  in  1  core decoded BRK; sampled only with inst_boundary
- inst_boundary  in  1  core is at FETCH; request may be taken this cycle
- i_flag  in  1  core P[I]
- pc_in  in  16  return PC to push (BRK: already PC+2)
- p_in  in  8  core status register
- s_in  in  8  core stack pointer (low byte)
- rd_data  in  8  memory read data; valid one cycle after mem_addr
- busy  out  1  sequencer owns the bus; core must hold
- mem_addr  out  16  bus address while busy
- mem_wdata  out  8  write data
- mem_we  out  1  write enable
- pc_out  out  16  vector loaded into PC
- pc_load  out  1  1-cycle strobe: core loads PC<=pc_out
- s_out  out  8  post-push stack pointer
- s_load  out  1  1-cycle strobe, coincident with pc_load
- set_i  out  1  1-cycle strobe: core sets P[I], coincident with pc_load
- src  out  2  serviced source (0 RST, 1 NMI, 2 BRK, 3 IRQ), valid with pc_load

Behaviour:
- Reset (resetn=0):
  - State IDLE. All outputs 0, including mem_addr/mem_wdata.
  - NMI edge latch cleared; synchronizers set to 1.
  - rst_pending set to 1.
- First cycle after resetn=1: rst_pending starts the sequence without waiting for inst_boundary.
- Source selection in IDLE with inst_boundary=1:
  - Priority: rst_pending > nmi_pending > brk_req > (irq_sync==0 && i_flag==0).
  - On take: latch pc_in, p_in, s_in and the source, then go to PUSH_H.
  - No eligible source: stay IDLE; busy stays 0.
- nmi_pending:
  - Set on a synchronized 1->0 transition of nmi_n; held until serviced.
  - Cleared on entry to VEC_L when the vector chosen is NMI.
  - An edge in the same cycle as the clear re-arms the latch; the set wins.
- IRQ is not latched. If irq_n deasserts before a boundary, it is not serviced.
- States and per-state outputs (all outputs registered and valid during the named state; busy=1 in every state except IDLE):
  - PUSH_H: mem_addr={STACK_PAGE,S}; mem_wdata=PC[15:8]; mem_we=1; S<=S-1.
  - PUSH_L: same address form; mem_wdata=PC[7:0]; S<=S-1.
  - PUSH_P: mem_wdata = P with bit5=1 and bit4 = (src==BRK); S<=S-1.
  - VEC_L: mem_addr=vector; mem_we=0.
  - VEC_H: mem_addr=vector+1; capture rd_data -> PCL.
  - LOAD: capture rd_data -> PCH; pulse pc_load, s_load and set_i; next state IDLE.
- Reset source:
  - Push states perform no writes (mem_we=0, dummy reads at the same addresses).
  - S still decrements by 3 (wraps 8-bit, e.g. 00 -> FD).
- Stack arithmetic wraps modulo 256 within STACK_PAGE: S=01 pushes to 0101, 0100, 01FF; s_out=FE.
- Vector choice is made at entry to VEC_L, not at take:
  - NMI hijack: an IRQ/BRK sequence whose nmi_pending is set before VEC_L uses NMI_VEC.
  - src reports NMI; the pushed P keeps the B bit of the original BRK.
- Latency: take at cycle T; PUSH_H at T+1; pc_load at T+6. Seven cycles total, including the boundary.
- Requests arriving while busy are held (NMI, reset) or ignored (BRK, IRQ level re-sampled at the next boundary).
- Reset mid-sequence: abort immediately to IDLE with outputs cleared; rst_pending restarts at resetn=1.

Decomposition:
- Shared package (params.vh): source codes SRC_RST/NMI/BRK/IRQ, state encodings, P bit indices (BREAK=4, UNUSED=5, IRQ_DISABLE=2), default vector addresses.
- Sub-module int_sync: SYNC_STAGES flop chain plus NMI falling-edge detector, instantiated for nmi_n and for irq_n.

Test Plan:
- Release resetn, mem[FFFC]=34, mem[FFFD]=12, s_in=00 -> no mem_we during the sequence; pc_out=1234, s_out=FD, src=0, pc_load at cycle 6.
- IRQ with irq_n=0, i_flag=0, pc_in=C005, p_in=20, s_in=FF -> writes 01FF<=C0, 01FE<=05, 01FD<=20; reads FFFE/FFFF; set_i pulses; s_out=FC.
- Same as above with i_flag=1 -> busy stays 0; then raise irq_n before clearing I -> never serviced.
- BRK and IRQ together at a boundary, p_in=00 -> BRK serviced; pushed P=30, src=2.
- IRQ entry with an nmi_n falling edge arriving two cycles after take -> vector fetched from FFFA/FFFB; src=1; nmi_pending cleared.
- S=01 push wrap, then resetn=0 during VEC_H -> addresses 0101/0100/01FF; abort leaves busy=0 and pc_load never pulses; after release a reset sequence runs.

Source files
------------

// File: rtl/int_seq_pkg.sv
// Shared definitions for the 6502 interrupt/reset entry sequencer.
// Holds source codes, FSM encodings, status-register bit positions and default vectors.
// Also provides the helper that forms the status byte pushed on entry.
package int_seq_pkg;

  // Serviced source codes, as reported on the src output
  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_BRK = 2'd2,
    SRC_IRQ = 2'd3
  } src_t;

  // Entry sequence states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH_H = 3'd1,
    ST_PUSH_L = 3'd2,
    ST_PUSH_P = 3'd3,
    ST_VEC_L  = 3'd4,
    ST_VEC_H  = 3'd5,
    ST_LOAD   = 3'd6
  } state_t;

  // Status register bit positions
  localparam int P_IRQ_DISABLE = 2;
  localparam int P_BREAK       = 4;
  localparam int P_UNUSED      = 5;

  // Default stack page and vector LSB addresses (MSB lives at +1)
  localparam logic [7:0]  DEF_STACK_PAGE = 8'h01;
  localparam logic [15:0] DEF_NMI_VEC    = 16'hFFFA;
  localparam logic [15:0] DEF_RST_VEC    = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC    = 16'hFFFE;

  // Pushed P always has the unused bit set; B is set only for BRK entries
  function automatic logic [7:0] push_status(input logic [7:0] p, input logic brk);
    logic [7:0] r;
    r           = p;
    r[P_UNUSED] = 1'b1;
    r[P_BREAK]  = brk;
    return r;
  endfunction

endpackage

// File: rtl/int_seq_sync.sv
// Multi-flop synchronizer for an async active-low input, plus a falling-edge pulse.
// Latency: STAGES cycles to dout; fall pulses for one cycle right after dout drops.
// No backpressure; the chain resets to 1 (inactive) so release never fakes an edge.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last;

  // Shift the async input through the chain; remember the previous synced value
  always_ff @(posedge clk) begin
    if (!resetn) begin
      chain <= '1;
      last  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      last  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign fall = last & ~chain[STAGES-1];

endmodule

// File: rtl/int_seq.sv
// Interrupt/reset entry sequencer: arbitrates RST/NMI/BRK/IRQ at instruction boundaries.
// Latency: take at T, stack pushes T+1..T+3, vector reads T+4..T+5, pc_load at T+6.
// Core stalls while busy=1; NMI and reset requests are held, BRK/IRQ re-sampled later.
module int_seq
  import int_seq_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE  = DEF_STACK_PAGE,
  parameter logic [15:0] NMI_VEC     = DEF_NMI_VEC,
  parameter logic [15:0] RST_VEC     = DEF_RST_VEC,
  parameter logic [15:0] IRQ_VEC     = DEF_IRQ_VEC,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        inst_boundary,
  input  logic        i_flag,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  s_in,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic [7:0]  s_out,
  output logic        s_load,
  output logic        set_i,
  output logic [1:0]  src
);

  state_t      state, state_nxt;
  logic [15:0] pc_lat, pc_lat_nxt;
  logic [7:0]  p_lat, p_lat_nxt;
  logic [7:0]  s_cur, s_nxt;
  src_t        src_lat, src_nxt;
  logic [15:0] vec_lat, vec_nxt;
  logic [7:0]  pcl, pcl_nxt;
  logic        rst_pending, rst_pend_nxt;
  logic        nmi_pending, nmi_pend_nxt;

  logic [15:0] mem_addr_nxt;
  logic [7:0]  mem_wdata_nxt;
  logic        mem_we_nxt;
  logic        pc_load_nxt;
  logic [7:0]  s_out_nxt;
  logic [1:0]  src_out_nxt;

  logic        take;
  src_t        take_src;
  logic        nmi_clr;

  logic        nmi_sync, nmi_fall;
  logic        irq_sync, irq_fall;
  logic        irq_fall_unused;

  int_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (nmi_n),
    .dout   (nmi_sync),
    .fall   (nmi_fall)
  );

  int_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (irq_n),
    .dout   (irq_sync),
    .fall   (irq_fall)
  );

  // IRQ is level-sensitive; its edge pulse has no consumer
  assign irq_fall_unused = irq_fall;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_nxt     = state;
    pc_lat_nxt    = pc_lat;
    p_lat_nxt     = p_lat;
    s_nxt         = s_cur;
    src_nxt       = src_lat;
    vec_nxt       = vec_lat;
    pcl_nxt       = pcl;
    rst_pend_nxt  = rst_pending;
    nmi_pend_nxt  = nmi_pending;
    mem_addr_nxt  = 16'h0000;
    mem_wdata_nxt = 8'h00;
    mem_we_nxt    = 1'b0;
    pc_load_nxt   = 1'b0;
    s_out_nxt     = 8'h00;
    src_out_nxt   = 2'd0;
    take          = 1'b0;
    take_src      = SRC_RST;
    nmi_clr       = 1'b0;

    // Pending reset does not wait for a boundary; the rest only at FETCH
    if (rst_pending) begin
      take     = 1'b1;
      take_src = SRC_RST;
    end else if (inst_boundary) begin
      if (nmi_pending) begin
        take     = 1'b1;
        take_src = SRC_NMI;
      end else if (brk_req) begin
        take     = 1'b1;
        take_src = SRC_BRK;
      end else if (!irq_sync && !i_flag) begin
        take     = 1'b1;
        take_src = SRC_IRQ;
      end
    end

    case (state)
      ST_IDLE: begin
        if (take) begin
          state_nxt     = ST_PUSH_H;
          pc_lat_nxt    = pc_in;
          p_lat_nxt     = p_in;
          src_nxt       = take_src;
          s_nxt         = s_in - 8'd1;
          mem_addr_nxt  = {STACK_PAGE, s_in};
          mem_wdata_nxt = pc_in[15:8];
          mem_we_nxt    = (take_src != SRC_RST);
          if (take_src == SRC_RST) rst_pend_nxt = 1'b0;
        end
      end
      ST_PUSH_H: begin
        state_nxt     = ST_PUSH_L;
        s_nxt         = s_cur - 8'd1;
        mem_addr_nxt  = {STACK_PAGE, s_cur};
        mem_wdata_nxt = pc_lat[7:0];
        mem_we_nxt    = (src_lat != SRC_RST);
      end
      ST_PUSH_L: begin
        state_nxt     = ST_PUSH_P;
        s_nxt         = s_cur - 8'd1;
        mem_addr_nxt  = {STACK_PAGE, s_cur};
        mem_wdata_nxt = push_status(p_lat, src_lat == SRC_BRK);
        mem_we_nxt    = (src_lat != SRC_RST);
      end
      ST_PUSH_P: begin
        // Vector chosen here so a late NMI can hijack an IRQ/BRK entry
        state_nxt = ST_VEC_L;
        if (src_lat == SRC_RST) begin
          vec_nxt = RST_VEC;
        end else if (src_lat == SRC_NMI || nmi_pending) begin
          vec_nxt = NMI_VEC;
          src_nxt = SRC_NMI;
          nmi_clr = 1'b1;
        end else begin
          vec_nxt = IRQ_VEC;
        end
        mem_addr_nxt = vec_nxt;
      end
      ST_VEC_L: begin
        state_nxt    = ST_VEC_H;
        mem_addr_nxt = vec_lat + 16'd1;
      end
      ST_VEC_H: begin
        state_nxt   = ST_LOAD;
        pcl_nxt     = rd_data;
        pc_load_nxt = 1'b1;
        s_out_nxt   = s_cur;
        src_out_nxt = src_lat;
      end
      ST_LOAD: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // An edge landing on the clear cycle re-arms the latch
    if (nmi_clr)  nmi_pend_nxt = 1'b0;
    if (nmi_fall) nmi_pend_nxt = 1'b1;
  end

  // State, datapath and output registers; reset also aborts a running sequence
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      pc_lat      <= 16'h0000;
      p_lat       <= 8'h00;
      s_cur       <= 8'h00;
      src_lat     <= SRC_RST;
      vec_lat     <= 16'h0000;
      pcl         <= 8'h00;
      rst_pending <= 1'b1;
      nmi_pending <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 8'h00;
      mem_we      <= 1'b0;
      pc_load     <= 1'b0;
      s_out       <= 8'h00;
      src         <= 2'd0;
    end else begin
      state       <= state_nxt;
      pc_lat      <= pc_lat_nxt;
      p_lat       <= p_lat_nxt;
      s_cur       <= s_nxt;
      src_lat     <= src_nxt;
      vec_lat     <= vec_nxt;
      pcl         <= pcl_nxt;
      rst_pending <= rst_pend_nxt;
      nmi_pending <= nmi_pend_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      mem_we      <= mem_we_nxt;
      pc_load     <= pc_load_nxt;
      s_out       <= s_out_nxt;
      src         <= src_out_nxt;
    end
  end

  assign busy   = (state != ST_IDLE);
  assign s_load = pc_load;
  assign set_i  = pc_load;

  // PCH arrives on rd_data during LOAD itself, so it is merged straight in
  assign pc_out = (state == ST_LOAD) ? {rd_data, pcl} : 16'h0000;

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: reset entry, IRQ, masking, BRK priority, NMI, hijack, wrap/abort.
// Memory model returns mem[mem_addr] one cycle after the address.
// Inputs driven 1ns after posedge; outputs sampled at the same point.
module tb_int_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        nmi_n, irq_n, brk_req, inst_boundary, i_flag;
  logic [15:0] pc_in;
  logic [7:0]  p_in, s_in;
  logic [7:0]  rd_data;
  logic        busy, mem_we, pc_load, s_load, set_i;
  logic [15:0] mem_addr, pc_out;
  logic [7:0]  mem_wdata, s_out;
  logic [1:0]  src;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mem [0:65535];

  logic [15:0] t_addr [1:7];
  logic [7:0]  t_wd   [1:7];
  logic        t_we   [1:7];
  logic        t_busy [1:7];
  logic        t_pcl  [1:7];
  logic        t_seti [1:7];
  logic        t_sld  [1:7];
  logic [15:0] t_pc   [1:7];
  logic [7:0]  t_s    [1:7];
  logic [1:0]  t_src  [1:7];

  always #5 clk = ~clk;

  // Synchronous-read memory
  always @(posedge clk) rd_data <= mem[mem_addr];

  int_seq dut (
    .clk           (clk),
    .resetn        (resetn),
    .nmi_n         (nmi_n),
    .irq_n         (irq_n),
    .brk_req       (brk_req),
    .inst_boundary (inst_boundary),
    .i_flag        (i_flag),
    .pc_in         (pc_in),
    .p_in          (p_in),
    .s_in          (s_in),
    .rd_data       (rd_data),
    .busy          (busy),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .pc_out        (pc_out),
    .pc_load       (pc_load),
    .s_out         (s_out),
    .s_load        (s_load),
    .set_i         (set_i),
    .src           (src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step through a take plus six cycles, recording outputs; optional reset at abort_at
  task automatic trace(input int abort_at);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) begin
        inst_boundary = 1'b0;
        brk_req       = 1'b0;
      end
      t_addr[k] = mem_addr;
      t_wd[k]   = mem_wdata;
      t_we[k]   = mem_we;
      t_busy[k] = busy;
      t_pcl[k]  = pc_load;
      t_seti[k] = set_i;
      t_sld[k]  = s_load;
      t_pc[k]   = pc_out;
      t_s[k]    = s_out;
      t_src[k]  = src;
      if (k == abort_at) resetn = 1'b0;
    end
  endtask

  task automatic idle_busy_check(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick();
      check(tag, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int nwe;
    int npl;

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h78; mem[16'hFFFF] = 8'h56;
    mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hAB;

    resetn = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; brk_req = 1'b0;
    inst_boundary = 1'b0; i_flag = 1'b1;
    pc_in = 16'h0000; p_in = 8'h00; s_in = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_busy",  {31'd0, busy},    32'd0);
    check("rst_addr",  {16'd0, mem_addr}, 32'd0);
    check("rst_we",    {31'd0, mem_we},  32'd0);
    check("rst_pcl",   {31'd0, pc_load}, 32'd0);
    check("rst_pcout", {16'd0, pc_out},  32'd0);

    // Reset entry: no writes, dummy reads, vector 1234, S 00 -> FD
    resetn = 1'b1;
    trace(0);
    nwe = 0; npl = 0;
    for (int k = 1; k <= 7; k++) begin
      nwe += int'(t_we[k]);
      npl += int'(t_pcl[k]);
    end
    check("res_no_we",   nwe, 0);
    check("res_npl",     npl, 1);
    check("res_busy1",   {31'd0, t_busy[1]}, 32'd1);
    check("res_a1",      {16'd0, t_addr[1]}, 32'h0100);
    check("res_a2",      {16'd0, t_addr[2]}, 32'h01FF);
    check("res_a3",      {16'd0, t_addr[3]}, 32'h01FE);
    check("res_a4",      {16'd0, t_addr[4]}, 32'hFFFC);
    check("res_a5",      {16'd0, t_addr[5]}, 32'hFFFD);
    check("res_pcl6",    {31'd0, t_pcl[6]},  32'd1);
    check("res_pc",      {16'd0, t_pc[6]},   32'h1234);
    check("res_s",       {24'd0, t_s[6]},    32'hFD);
    check("res_src",     {30'd0, t_src[6]},  32'd0);
    check("res_busy7",   {31'd0, t_busy[7]}, 32'd0);

    // IRQ entry
    i_flag = 1'b0; irq_n = 1'b0;
    repeat (3) tick();
    pc_in = 16'hC005; p_in = 8'h20; s_in = 8'hFF; inst_boundary = 1'b1;
    trace(0);
    irq_n = 1'b1; i_flag = 1'b1;
    check("irq_a1",  {16'd0, t_addr[1]}, 32'h01FF);
    check("irq_w1",  {24'd0, t_wd[1]},   32'hC0);
    check("irq_we1", {31'd0, t_we[1]},   32'd1);
    check("irq_a2",  {16'd0, t_addr[2]}, 32'h01FE);
    check("irq_w2",  {24'd0, t_wd[2]},   32'h05);
    check("irq_a3",  {16'd0, t_addr[3]}, 32'h01FD);
    check("irq_w3",  {24'd0, t_wd[3]},   32'h20);
    check("irq_a4",  {16'd0, t_addr[4]}, 32'hFFFE);
    check("irq_we4", {31'd0, t_we[4]},   32'd0);
    check("irq_a5",  {16'd0, t_addr[5]}, 32'hFFFF);
    check("irq_seti",{31'd0, t_seti[6]}, 32'd1);
    check("irq_sld", {31'd0, t_sld[6]},  32'd1);
    check("irq_s",   {24'd0, t_s[6]},    32'hFC);
    check("irq_src", {30'd0, t_src[6]},  32'd3);
    check("irq_pc",  {16'd0, t_pc[6]},   32'h5678);
    repeat (3) tick();

    // Masked IRQ, then IRQ withdrawn before I is cleared
    irq_n = 1'b0;
    repeat (3) tick();
    inst_boundary = 1'b1;
    idle_busy_check("mask_busy", 4);
    irq_n = 1'b1;
    repeat (3) tick();
    i_flag = 1'b0;
    idle_busy_check("gone_busy", 4);
    inst_boundary = 1'b0;

    // BRK and IRQ together: BRK wins, B set in pushed P
    irq_n = 1'b0;
    repeat (3) tick();
    brk_req = 1'b1; pc_in = 16'h1002; p_in = 8'h00; s_in = 8'hF0; inst_boundary = 1'b1;
    trace(0);
    irq_n = 1'b1; i_flag = 1'b1;
    check("brk_a1",  {16'd0, t_addr[1]}, 32'h01F0);
    check("brk_w1",  {24'd0, t_wd[1]},   32'h10);
    check("brk_w2",  {24'd0, t_wd[2]},   32'h02);
    check("brk_a3",  {16'd0, t_addr[3]}, 32'h01EE);
    check("brk_w3",  {24'd0, t_wd[3]},   32'h30);
    check("brk_a4",  {16'd0, t_addr[4]}, 32'hFFFE);
    check("brk_src", {30'd0, t_src[6]},  32'd2);
    check("brk_s",   {24'd0, t_s[6]},    32'hED);
    repeat (3) tick();

    // NMI edge while no boundary is held, then taken despite I=1
    nmi_n = 1'b0;
    repeat (4) tick();
    nmi_n = 1'b1;
    repeat (2) tick();
    check("nmi_held_busy", {31'd0, busy}, 32'd0);
    pc_in = 16'h3000; p_in = 8'h04; s_in = 8'h40; inst_boundary = 1'b1;
    trace(0);
    check("nmi_a4",  {16'd0, t_addr[4]}, 32'hFFFA);
    check("nmi_w3",  {24'd0, t_wd[3]},   32'h24);
    check("nmi_src", {30'd0, t_src[6]},  32'd1);
    check("nmi_pc",  {16'd0, t_pc[6]},   32'hABCD);
    inst_boundary = 1'b1;
    idle_busy_check("nmi_clr_busy", 3);
    inst_boundary = 1'b0;

    // IRQ hijacked by NMI: nmi_n drops in the take cycle, synced edge two cycles later
    i_flag = 1'b0; irq_n = 1'b0;
    repeat (3) tick();
    pc_in = 16'h2000; p_in = 8'h00; s_in = 8'h80; inst_boundary = 1'b1; nmi_n = 1'b0;
    trace(0);
    irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b1;
    check("hj_a1",  {16'd0, t_addr[1]}, 32'h0180);
    check("hj_w3",  {24'd0, t_wd[3]},   32'h20);
    check("hj_a4",  {16'd0, t_addr[4]}, 32'hFFFA);
    check("hj_a5",  {16'd0, t_addr[5]}, 32'hFFFB);
    check("hj_src", {30'd0, t_src[6]},  32'd1);
    check("hj_pc",  {16'd0, t_pc[6]},   32'hABCD);
    repeat (3) tick();
    inst_boundary = 1'b1;
    idle_busy_check("hj_clr_busy", 3);
    inst_boundary = 1'b0;

    // Stack wrap from S=01, then reset during VEC_H
    i_flag = 1'b0; irq_n = 1'b0;
    repeat (3) tick();
    pc_in = 16'h4455; p_in = 8'h00; s_in = 8'h01; inst_boundary = 1'b1;
    trace(5);
    irq_n = 1'b1; i_flag = 1'b1;
    check("wr_a1",    {16'd0, t_addr[1]}, 32'h0101);
    check("wr_a2",    {16'd0, t_addr[2]}, 32'h0100);
    check("wr_a3",    {16'd0, t_addr[3]}, 32'h01FF);
    check("wr_a5",    {16'd0, t_addr[5]}, 32'hFFFF);
    check("ab_busy",  {31'd0, t_busy[6]}, 32'd0);
    check("ab_addr",  {16'd0, t_addr[6]}, 32'd0);
    check("ab_pcl6",  {31'd0, t_pcl[6]},  32'd0);
    check("ab_pcl7",  {31'd0, t_pcl[7]},  32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    trace(0);
    nwe = 0;
    for (int k = 1; k <= 7; k++) nwe += int'(t_we[k]);
    check("rr_no_we", nwe, 0);
    check("rr_pcl6",  {31'd0, t_pcl[6]},  32'd1);
    check("rr_pc",    {16'd0, t_pc[6]},   32'h1234);
    check("rr_s",     {24'd0, t_s[6]},    32'hFE);
    check("rr_src",   {30'd0, t_src[6]},  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
